// File: rtl/emu_time_sched.sv
// Emulation timestep scheduler: grants the smallest enabled timestep request
// each cycle, clamps it so emulation time lands exactly on a programmable stop
// time, accumulates emulation time and sequences IDLE/RUN/DONE.
// The accumulator arithmetic assumes DT_WIDTH <= TIME_WIDTH.
module emu_time_sched #(
    parameter int N_REQ      = 4,
    parameter int DT_WIDTH   = 27,
    parameter int TIME_WIDTH = 40,
    parameter int DT_MAX     = 2**26
) (
    input  logic                          emu_clk,
    input  logic                          emu_rst,
    input  logic [N_REQ*DT_WIDTH-1:0]     dt_req,
    input  logic [N_REQ-1:0]              dt_req_en,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          clear,
    input  logic [TIME_WIDTH-1:0]         tstop,
    input  logic                          tstop_en,
    output logic [DT_WIDTH-1:0]           emu_dt,
    output logic [TIME_WIDTH-1:0]         emu_time,
    output logic [$clog2(N_REQ+1)-1:0]    dt_src,
    output logic                          running,
    output logic                          done,
    output logic                          overflow
);

    localparam int SRC_W = $clog2(N_REQ+1);
    localparam logic [DT_WIDTH-1:0] DT_MAX_V = DT_WIDTH'(DT_MAX);
    localparam logic [SRC_W-1:0]    SRC_NONE = SRC_W'(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                  state;
    logic [DT_WIDTH-1:0]     dt_next;
    logic [SRC_W-1:0]        src_next;
    logic [TIME_WIDTH-1:0]   rem;
    logic [TIME_WIDTH:0]     sum;
    logic                    hit_stop;

    // Minimum-request search followed by the stop-time clamp.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        dt_next  = DT_MAX_V;
        src_next = SRC_NONE;
        rem      = '0;
        // NOTE: blocking assignments here so each loop iteration sees the
        // running minimum left by the previous one.
        for (int i = 0; i < N_REQ; i++) begin
            if (dt_req_en[i] && (dt_req[i*DT_WIDTH +: DT_WIDTH] < dt_next)) begin
                dt_next  = dt_req[i*DT_WIDTH +: DT_WIDTH];
                src_next = SRC_W'(i);
            end
        end
        if (tstop_en) begin
            rem = (tstop > emu_time) ? (tstop - emu_time) : '0;
            if (rem < TIME_WIDTH'(dt_next)) begin
                dt_next = rem[DT_WIDTH-1:0];
            end
        end
    end

    // Next time with carry-out kept, and the stop-time reached condition.
    always_comb begin
        sum      = {1'b0, emu_time} + (TIME_WIDTH+1)'(dt_next);
        hit_stop = tstop_en && (sum >= {1'b0, tstop});
    end

    // Run/pause/done sequencer with registered grant, time and status.
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        // NOTE: non-blocking assignments for all state so every register
        // samples the pre-edge values regardless of statement order.
        if (emu_rst) begin
            state    <= ST_IDLE;
            emu_dt   <= '0;
            emu_time <= '0;
            dt_src   <= SRC_NONE;
            running  <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            state    <= ST_IDLE;
            emu_dt   <= '0;
            emu_time <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    emu_dt <= '0;
                    if (start && !stop) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                        emu_dt  <= '0;
                    end else begin
                        emu_dt   <= dt_next;
                        emu_time <= sum[TIME_WIDTH-1:0];
                        dt_src   <= src_next;
                        if (sum[TIME_WIDTH]) begin
                            overflow <= 1'b1;
                        end
                        if (hit_stop) begin
                            state   <= ST_DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    emu_dt <= '0;
                end
                default: begin
                    state   <= ST_IDLE;
                    emu_dt  <= '0;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_emu_time_sched.sv
// Self-checking bench for emu_time_sched: directed scenarios plus a random
// phase, all compared against a behavioural scheduler model, and a narrow
// 8-bit-time instance for wrap/overflow and asynchronous reset.
module tb_emu_time_sched;

    localparam longint unsigned DTMAX = 64'd67108864;
    localparam longint unsigned TMOD  = 64'd1 << 40;

    logic               emu_clk = 1'b0;
    logic               emu_rst;
    logic [107:0]       dt_req;
    logic [3:0]         dt_req_en;
    logic               start, stop, clear;
    logic [39:0]        tstop;
    logic               tstop_en;
    logic [26:0]        emu_dt;
    logic [39:0]        emu_time;
    logic [2:0]         dt_src;
    logic               running, done, overflow;

    // narrow instance: 8-bit time, 8-bit steps, one requester
    logic [7:0]         s_req;
    logic               s_en, s_start;
    logic [7:0]         s_dt, s_time;
    logic               s_src, s_running, s_done, s_overflow;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int unsigned        r [4];
    longint unsigned    m_time, m_dt;
    int                 m_src;
    bit                 m_run, m_done, m_ovf;

    always #5 emu_clk = ~emu_clk;

    emu_time_sched dut (
        .emu_clk(emu_clk), .emu_rst(emu_rst), .dt_req(dt_req), .dt_req_en(dt_req_en),
        .start(start), .stop(stop), .clear(clear), .tstop(tstop), .tstop_en(tstop_en),
        .emu_dt(emu_dt), .emu_time(emu_time), .dt_src(dt_src), .running(running),
        .done(done), .overflow(overflow)
    );

    emu_time_sched #(.N_REQ(1), .DT_WIDTH(8), .TIME_WIDTH(8), .DT_MAX(128)) dut_s (
        .emu_clk(emu_clk), .emu_rst(emu_rst), .dt_req(s_req), .dt_req_en(s_en),
        .start(s_start), .stop(1'b0), .clear(1'b0), .tstop(8'd0), .tstop_en(1'b0),
        .emu_dt(s_dt), .emu_time(s_time), .dt_src(s_src), .running(s_running),
        .done(s_done), .overflow(s_overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_time = 0; m_dt = 0; m_src = 4;
        m_run = 0; m_done = 0; m_ovf = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dt"},   emu_dt,   m_dt);
        check({tag, ".time"}, emu_time, m_time);
        check({tag, ".src"},  dt_src,   m_src);
        check({tag, ".run"},  running,  m_run);
        check({tag, ".done"}, done,     m_done);
        check({tag, ".ovf"},  overflow, m_ovf);
    endtask

    // One clock edge: derive the grant from the rules, advance model, compare.
    task automatic step(input string tag);
        longint unsigned g, rem, s;
        int  src_c;
        bit  st, sp, cl, te;
        longint unsigned ts;
        dt_req = {r[3][26:0], r[2][26:0], r[1][26:0], r[0][26:0]};
        g = DTMAX; src_c = 4;
        for (int i = 0; i < 4; i++)
            if (dt_req_en[i] && r[i] < g) begin g = r[i]; src_c = i; end
        te = tstop_en; ts = tstop;
        if (te) begin
            rem = (ts > m_time) ? ts - m_time : 0;
            if (rem < g) g = rem;
        end
        st = start; sp = stop; cl = clear;
        @(posedge emu_clk); #1;
        start = 0; stop = 0; clear = 0;
        if (cl) begin
            m_time = 0; m_ovf = 0; m_run = 0; m_done = 0; m_dt = 0;
        end else if (m_run) begin
            if (sp) begin
                m_run = 0; m_dt = 0;
            end else begin
                s = m_time + g;
                m_dt = g; m_src = src_c;
                if (s >= TMOD) m_ovf = 1;
                m_time = s % TMOD;
                if (te && s >= ts) begin m_run = 0; m_done = 1; end
            end
        end else if (m_done) begin
            m_dt = 0;
        end else begin
            m_dt = 0;
            if (st && !sp) m_run = 1;
        end
        check_all(tag);
    endtask

    initial begin
        emu_rst = 1; dt_req = '0; dt_req_en = '0; start = 0; stop = 0; clear = 0;
        tstop = '0; tstop_en = 0; s_req = '0; s_en = 0; s_start = 0;
        for (int i = 0; i < 4; i++) r[i] = 0;
        model_reset();
        #12;
        check_all("reset");
        check("reset.s_time", s_time, 0);
        check("reset.s_src", s_src, 1);
        @(posedge emu_clk); #1 emu_rst = 0;

        // lowest minimum with a tie: requester 1 wins
        r[0] = 100; r[1] = 40; r[2] = 70; r[3] = 40; dt_req_en = 4'b1111;
        start = 1; step("t1_start");
        check("t1_nogrant", emu_dt, 0);
        for (int k = 0; k < 4; k++) step("t1_run");
        check("t1_time", emu_time, 160);
        check("t1_src", dt_src, 1);
        stop = 1; step("t1_stop");
        clear = 1; step("t1_clear");

        // nothing enabled: DT_MAX granted, source = none
        dt_req_en = 4'b0000;
        start = 1; step("t2_start");
        for (int k = 0; k < 3; k++) step("t2_run");
        check("t2_dt", emu_dt, DTMAX);
        check("t2_src", dt_src, 4);
        stop = 1; step("t2_stop");
        clear = 1; step("t2_clear");

        // stop-time clamp: 100,100,50 then DONE, start ignored
        r[0] = 100; dt_req_en = 4'b0001; tstop = 40'd250; tstop_en = 1;
        start = 1; step("t3_start");
        for (int k = 0; k < 3; k++) step("t3_run");
        check("t3_time", emu_time, 250);
        check("t3_dt", emu_dt, 50);
        check("t3_done", done, 1);
        start = 1; step("t3_ign");
        start = 1; step("t3_ign");
        check("t3_held", emu_dt, 0);
        clear = 1; step("t3_clear");
        check("t3_cleared", emu_time, 0);

        // pause at 300, resume from there
        tstop_en = 0;
        start = 1; step("t4_start");
        for (int k = 0; k < 3; k++) step("t4_run");
        stop = 1; step("t4_stop");
        check("t4_paused", emu_time, 300);
        step("t4_idle");
        start = 1; step("t4_restart");
        step("t4_resume");
        check("t4_resumed", emu_time, 400);

        // start+stop together from IDLE stays IDLE; zero request stalls
        stop = 1; step("t5_stop");
        start = 1; stop = 1; step("t5_both");
        check("t5_idle", running, 0);
        r[0] = 0; start = 1; step("t5_start");
        step("t5_stall");
        check("t5_zero", emu_dt, 0);
        check("t5_still_run", running, 1);
        // tstop lowered below current time: zero step then DONE
        tstop = 40'd10; tstop_en = 1; r[0] = 100;
        step("t5_low");
        check("t5_done", done, 1);
        clear = 1; start = 1; step("t5_clear");
        check("t5_clr_done", done, 0);

        // randomized phase
        tstop_en = 0;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 15) == 0) r[i] = 32'(DTMAX);
                else if ($urandom_range(0, 5) == 0) r[i] = $urandom_range(0, 3);
                else r[i] = $urandom_range(1, 3000);
            end
            dt_req_en = 4'($urandom_range(0, 15));
            start = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 20) == 0);
            clear = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 15) == 0) begin
                tstop_en = ~tstop_en;
                if (m_time > 500 && $urandom_range(0, 3) == 0) tstop = 40'(m_time - 100);
                else tstop = 40'(m_time + $urandom_range(0, 20000));
            end
            step("rand");
        end

        // narrow instance: 8-bit time wraps 100,200,44 and overflow sticks
        s_req = 8'd100; s_en = 1; s_start = 1;
        @(posedge emu_clk); #1 s_start = 0;
        begin
            int exp_t [4] = '{100, 200, 44, 144};
            bit exp_o [4] = '{0, 0, 1, 1};
            for (int k = 0; k < 4; k++) begin
                @(posedge emu_clk); #1;
                check("wrap.time", s_time, exp_t[k]);
                check("wrap.ovf", s_overflow, exp_o[k]);
                check("wrap.dt", s_dt, 100);
            end
        end
        check("wrap.run", s_running, 1);

        // asynchronous reset mid-cycle
        #3 emu_rst = 1;
        #1;
        model_reset();
        check("arst.s_time", s_time, 0);
        check("arst.s_dt", s_dt, 0);
        check("arst.s_ovf", s_overflow, 0);
        check("arst.s_run", s_running, 0);
        check("arst.s_src", s_src, 1);
        check_all("arst");
        #2 emu_rst = 0;
        step("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/emu_time_sched.md
Name: emu_time_sched

Overview:
- Emulation timestep scheduler for the analog emulation top level.
- Each cycle it collects timestep requests from N_REQ analog model blocks and grants the smallest one as the global step emu_dt.
- The grant is clamped so that emulation time never overshoots a programmable stop time.
- It accumulates emulation time and sequences run/pause/done, replacing the fixed-DT free-running clock with a controlled, variable-step one.

Parameters:
- N_REQ, 4, number of timestep requesters.
- DT_WIDTH, 27, width of timestep values (unsigned fixed-point, same LSB as time).
- TIME_WIDTH, 40, width of the emulation time accumulator.
- DT_MAX, 2**26, step granted when no requester is enabled; also the upper clamp on any grant.

Ports:
- emu_clk  in  1  emulation clock.
- emu_rst  in  1  asynchronous active-high reset.
- dt_req  in  N_REQ*DT_WIDTH  requested steps; requester i occupies bits [i*DT_WIDTH +: DT_WIDTH].
- dt_req_en  in  N_REQ  requester i participates when bit i is 1.
- start  in  1  single-cycle pulse: IDLE->RUN.
- stop  in  1  single-cycle pulse: RUN->IDLE (pause; time retained).
- clear  in  1  single-cycle pulse: emu_time<=0, overflow<=0, state<=IDLE.
- tstop  in  TIME_WIDTH  stop time.
- tstop_en  in  1  enables the stop-time clamp and the DONE transition.
- emu_dt  out  DT_WIDTH  granted step (registered).
- emu_time  out  TIME_WIDTH  emulation time after emu_dt is applied (registered).
- dt_src  out  $clog2(N_REQ+1)  index of the winning requester; N_REQ means none enabled/DT_MAX won.
- running  out  1  state==RUN.
- done  out  1  state==DONE.
- overflow  out  1  sticky; emu_time wrapped.

Behaviour:
- Reset (async, emu_rst=1): state=IDLE, emu_dt=0, emu_time=0, dt_src=N_REQ, running=0, done=0, overflow=0.
- States: IDLE, RUN, DONE; encoding is free.
- Combinational dt_next:
  - Start from m = DT_MAX, src = N_REQ.
  - For each enabled i with dt_req[i] < m: m = dt_req[i], src = i. Strict < gives the lowest index priority on ties; a request equal to DT_MAX loses to the none-enabled default.
  - If tstop_en: rem = tstop - emu_time, saturating to 0 when tstop <= emu_time; if rem < m then m = rem. src is unchanged by the clamp.
- Zero-valued requests are legal: they grant a 0 step (an emulation stall cycle) and do not stop the run.
- IDLE:
  - emu_dt<=0; emu_time held.
  - start -> RUN. No step is granted on the start edge; the first grant is on the next edge.
- RUN, every edge:
  - emu_dt<=dt_next; emu_time<=emu_time+dt_next; dt_src<=src.
  - Latency: requests sampled at edge k appear on emu_dt/emu_time after edge k.
  - If tstop_en and emu_time+dt_next >= tstop (exactly == under the clamp): -> DONE on the same edge.
  - If stop: -> IDLE; emu_dt<=0; time not advanced on that edge.
- DONE:
  - emu_dt<=0; emu_time held.
  - start and stop are ignored; only clear leaves DONE.
- Wrap: when tstop_en=0, emu_time wraps modulo 2**TIME_WIDTH. Any carry-out sets overflow (sticky until clear/reset).
- Simultaneous events, priority clear > stop > start:
  - clear with stop or start: clear wins and the state goes to IDLE.
  - stop with start: stop wins.
- tstop lowered below emu_time while in RUN: rem=0, so the next edge grants emu_dt=0 and enters DONE.
- tstop_en deasserted while in RUN: unclamped running continues. tstop_en has no effect in DONE.
- running and done are registered decodes of the state, with no combinational path from the inputs.

Test Plan:
- Reset then start, N_REQ=4, requests {100,40,70,40}, all enabled, tstop_en=0 -> from the 2nd edge after start emu_dt=40, dt_src=1 (lowest-index tie), emu_time=40,80,120...
- dt_req_en=0000, start -> emu_dt=DT_MAX, dt_src=4; emu_time increments by DT_MAX per cycle.
- tstop_en=1, tstop=250, single requester dt=100 -> grants 100,100,50; emu_time=100,200,250; done=1 after the 3rd grant edge; later start pulses are ignored and emu_dt stays 0.
- Running at emu_time=300, pulse stop -> running=0, emu_dt=0, emu_time=300 held; start -> resumes at 300+dt.
- start and stop in the same cycle from IDLE -> remains IDLE. clear in DONE -> emu_time=0, done=0, state IDLE.
- TIME_WIDTH=8, tstop_en=0, dt=100 -> emu_time sequence 100,200,44; overflow=1 and stays set; emu_rst asserted mid-run -> all outputs return to reset values immediately, without waiting for an edge.
